btb_update: RTL

//  Write-side companion of the BTB. Sits at the end of EX, where branches resolve.

---
 rtl/btb_update.sv | 101 ++++++++++
 1 files changed

// File: rtl/btb_update.sv
// BTB write-side companion: detects mispredicts at the end of EX, issues a registered
// fetch redirect, and queues BTB write requests in a small FIFO drained one per cycle.
module btb_update #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned IDX_W = 10
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         ex_valid,
   output logic                         ex_ready,
   input  logic [31:0]                  ex_pc,
   input  logic                         ex_taken,
   input  logic [31:0]                  ex_target,
   input  logic                         ex_pred_hit,
   input  logic                         ex_pred_taken,
   input  logic [31:0]                  ex_pred_target,
   input  logic [IDX_W-1:0]             ex_index,
   output logic                         redirect,
   output logic [31:0]                  redirect_pc,
   output logic                         btb_wen,
   input  logic                         btb_ready,
   output logic [IDX_W-1:0]             btb_index_w,
   output logic [31:0]                  btb_pc_w,
   output logic [31:0]                  btb_target_w,
   output logic [$clog2(DEPTH+1)-1:0]   count
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = $clog2(DEPTH + 1);

   typedef struct packed {
      logic [IDX_W-1:0] idx;
      logic [31:0]      pc;
      logic [31:0]      target;
   } entry_t;

   entry_t           mem [DEPTH];
   logic [PTR_W-1:0] head;
   logic [PTR_W-1:0] tail;
   logic [PTR_W-1:0] newest;

   logic pop;
   logic accept;
   logic mispredict;
   logic need_upd;
   logic coalesce;
   logic push;
   logic [31:0] restart_pc;

   // Handshake and classification of the resolving branch
   always_comb begin
      newest     = tail - PTR_W'(1);
      btb_wen    = (count != '0);
      pop        = btb_wen && btb_ready;
      ex_ready   = (count < CNT_W'(DEPTH)) || pop;
      accept     = ex_valid && ex_ready;
      mispredict = accept && ((ex_taken != ex_pred_taken) ||
                   (ex_taken && (!ex_pred_hit || (ex_pred_target != ex_target))));
      need_upd   = accept && (!ex_pred_hit || (ex_pred_target != ex_target));
      // The newest entry can only be the one popped when it is also the head
      coalesce   = need_upd && (count != '0) && (mem[newest].pc == ex_pc) &&
                   !(pop && (count == CNT_W'(1)));
      push       = need_upd && !coalesce;
      restart_pc = ex_taken ? ex_target : (ex_pc + 32'd8);
   end

   assign btb_index_w  = mem[head].idx;
   assign btb_pc_w     = mem[head].pc;
   assign btb_target_w = mem[head].target;

   // Redirect register and FIFO state
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         redirect    <= 1'b0;
         redirect_pc <= '0;
         head        <= '0;
         tail        <= '0;
         count       <= '0;
         for (int unsigned i = 0; i < DEPTH; i++) begin
            mem[PTR_W'(i)] <= '0;
         end
      end else begin
         redirect <= mispredict;
         if (mispredict) begin
            redirect_pc <= restart_pc;
         end
         if (push) begin
            mem[tail] <= '{idx: ex_index, pc: ex_pc, target: ex_target};
            tail      <= tail + PTR_W'(1);
         end
         if (coalesce) begin
            mem[newest].target <= ex_target;
         end
         if (pop) begin
            head <= head + PTR_W'(1);
         end
         count <= count + CNT_W'(push) - CNT_W'(pop);
      end
   end

endmodule
